// File: rtl/msrh_conf_pkg.sv
// Core-wide configuration shared by the issue pipeline.
package msrh_conf_pkg;

  localparam int unsigned DISP_SIZE = 4;

endpackage : msrh_conf_pkg

// File: rtl/msrh_pkg.sv
// Common types and helpers for the issue unit.
package msrh_pkg;

  import msrh_conf_pkg::*;

  localparam int unsigned SA_LANE_W    = (DISP_SIZE > 1) ? $clog2(DISP_SIZE) : 1;
  localparam int unsigned POPCNT_MAX_W = 64;

  typedef logic [SA_LANE_W-1:0] sched_alloc_lane_t;

  // Bit count over a zero-extended vector; callers keep their width <= POPCNT_MAX_W.
  function automatic logic [6:0] popcount(input logic [POPCNT_MAX_W-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int unsigned i = 0; i < POPCNT_MAX_W; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage : msrh_pkg

// File: rtl/msrh_sched_alloc_if.sv
// Dispatch-side handshake between the dispatch stage and the scheduler allocator.
interface msrh_sched_alloc_if
  import msrh_conf_pkg::*;
#(
  parameter int unsigned ENTRY_SIZE = 16
) ();

  localparam int unsigned ENTRY_W = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1;

  logic                                disp_valid;
  logic [DISP_SIZE-1:0]                disp_lane_en;
  logic                                disp_ready;
  logic [DISP_SIZE-1:0][ENTRY_W-1:0]   lane_idx;

  modport master (
    output disp_valid,
    output disp_lane_en,
    input  disp_ready,
    input  lane_idx
  );

  modport slave (
    input  disp_valid,
    input  disp_lane_en,
    output disp_ready,
    output lane_idx
  );

endinterface : msrh_sched_alloc_if

// File: rtl/msrh_pick_lowest_n.sv
// Cascaded priority encoders: each enabled lane takes the lowest request bit
// not already taken by a lower lane.
module msrh_pick_lowest_n
  import msrh_conf_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned D = DISP_SIZE
) (
  input  logic [N-1:0]         i_req,
  input  logic [D-1:0]         i_lane_en,
  output logic [D-1:0][N-1:0]  o_pick
);

  logic [D-1:0][N-1:0] w_avail;
  logic [D-1:0][N-1:0] w_lowest;

  assign w_avail[0] = i_req;

  for (genvar k = 0; k < D; k++) begin : g_lane
    // Two's-complement trick isolates the lowest set bit.
    assign w_lowest[k] = w_avail[k] & (~w_avail[k] + N'(1));
    assign o_pick[k]   = i_lane_en[k] ? w_lowest[k] : '0;
    if (k + 1 < D) begin : g_next
      assign w_avail[k+1] = w_avail[k] & ~o_pick[k];
    end
  end

endmodule : msrh_pick_lowest_n

// File: rtl/msrh_sched_alloc.sv
// Scheduler entry allocator: grants free entries to dispatch lanes, reclaims
// finished entries and reports free credits.
module msrh_sched_alloc
  import msrh_conf_pkg::*;
  import msrh_pkg::*;
#(
  parameter int unsigned ENTRY_SIZE = 16,
  parameter int unsigned ENTRY_W    = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1,
  parameter int unsigned CNT_W      = $clog2(ENTRY_SIZE + 1)
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  msrh_sched_alloc_if.slave                   disp_if,
  output logic [ENTRY_SIZE-1:0]               o_entry_put,
  output sched_alloc_lane_t [ENTRY_SIZE-1:0]  o_entry_lane,
  input  logic [ENTRY_SIZE-1:0]               i_entry_finish,
  output logic [CNT_W-1:0]                    o_free_cnt,
  output logic                                o_empty,
  output logic                                o_err_double_free
);

  logic [ENTRY_SIZE-1:0]                r_free;
  logic [CNT_W-1:0]                     r_free_cnt;
  logic                                 r_err;
  logic                                 r_empty;

  logic                                 w_ready;
  logic                                 w_fire;
  logic [DISP_SIZE-1:0]                 w_lane_mask;
  logic [DISP_SIZE-1:0][ENTRY_SIZE-1:0] w_pick;
  logic [ENTRY_SIZE-1:0]                w_alloc;
  sched_alloc_lane_t [ENTRY_SIZE-1:0]   w_entry_lane;
  logic [DISP_SIZE-1:0][ENTRY_W-1:0]    w_lane_idx;
  logic [ENTRY_SIZE-1:0]                w_free_next;
  logic [ENTRY_SIZE-1:0]                w_reclaim;
  logic [CNT_W-1:0]                     w_cnt_next;

  // Ready looks only at the registered count so dispatch never sees a comb path back.
  assign w_ready     = (r_free_cnt >= CNT_W'(DISP_SIZE));
  assign w_fire      = disp_if.disp_valid & w_ready & ~i_reset;
  assign w_lane_mask = w_fire ? disp_if.disp_lane_en : '0;

  msrh_pick_lowest_n #(
    .N (ENTRY_SIZE),
    .D (DISP_SIZE)
  ) u_pick (
    .i_req     (r_free),
    .i_lane_en (w_lane_mask),
    .o_pick    (w_pick)
  );

  // Fold the per-lane one-hot picks into entry strobes and index views.
  always_comb begin
    w_alloc      = '0;
    w_entry_lane = '0;
    w_lane_idx   = '0;
    for (int unsigned k = 0; k < DISP_SIZE; k++) begin
      for (int unsigned e = 0; e < ENTRY_SIZE; e++) begin
        if (w_pick[k][e]) begin
          w_alloc[e]      = 1'b1;
          w_entry_lane[e] = SA_LANE_W'(k);
          w_lane_idx[k]   = ENTRY_W'(e);
        end
      end
    end
  end

  // Finish wins over a same-cycle alloc, so such a slot counts as reclaimed too;
  // this keeps the counter equal to the bitmap population.
  assign w_free_next = (r_free & ~w_alloc) | i_entry_finish;
  assign w_reclaim   = i_entry_finish & (~r_free | w_alloc);
  assign w_cnt_next  = r_free_cnt
                     - CNT_W'(popcount(POPCNT_MAX_W'(w_alloc)))
                     + CNT_W'(popcount(POPCNT_MAX_W'(w_reclaim)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_free     <= '1;
      r_free_cnt <= CNT_W'(ENTRY_SIZE);
      r_err      <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      r_free     <= w_free_next;
      r_free_cnt <= w_cnt_next;
      r_err      <= r_err | (|(i_entry_finish & r_free));
      r_empty    <= (w_cnt_next == CNT_W'(ENTRY_SIZE));
    end
  end

  assign disp_if.disp_ready = w_ready;
  assign disp_if.lane_idx   = w_lane_idx;
  assign o_entry_put        = w_alloc;
  assign o_entry_lane       = w_entry_lane;
  assign o_free_cnt         = r_free_cnt;
  assign o_empty            = r_empty;
  assign o_err_double_free  = r_err;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (r_free_cnt == CNT_W'(popcount(POPCNT_MAX_W'(r_free))));
    end
  end
`endif

endmodule : msrh_sched_alloc

// File: tb/tb_msrh_sched_alloc.sv
// Directed and model-checked random bench for the scheduler entry allocator.
module tb_msrh_sched_alloc;

  import msrh_conf_pkg::*;
  import msrh_pkg::*;

  localparam int unsigned ES = 16;
  localparam int unsigned EW = 4;
  localparam int unsigned CW = 5;
  localparam int unsigned LW = SA_LANE_W;

  logic                        clk;
  logic                        rst;
  logic [ES-1:0]               put;
  sched_alloc_lane_t [ES-1:0]  elane;
  logic [ES-1:0]               fin;
  logic [CW-1:0]               cnt;
  logic                        empty;
  logic                        err;

  int n_checks;
  int n_errors;

  msrh_sched_alloc_if #(.ENTRY_SIZE(ES)) dif ();

  msrh_sched_alloc #(.ENTRY_SIZE(ES)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .disp_if           (dif),
    .o_entry_put       (put),
    .o_entry_lane      (elane),
    .i_entry_finish    (fin),
    .o_free_cnt        (cnt),
    .o_empty           (empty),
    .o_err_double_free (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic v, input logic [DISP_SIZE-1:0] en, input logic [ES-1:0] f);
    @(negedge clk);
    dif.disp_valid   = v;
    dif.disp_lane_en = en;
    fin              = f;
    #1;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, '0, '0);
    post();
    post();
    rst = 1'b0;
    cyc(1'b0, '0, '0);
    n_checks++; if (dif.disp_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b exp 1", dif.disp_ready); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_checks++; if (put !== '0) begin n_errors++; $display("FAIL reset_put got %h exp 0", put); end
    n_checks++; if (elane !== '0) begin n_errors++; $display("FAIL reset_entry_lane got %h exp 0", elane); end
    n_checks++; if (dif.lane_idx !== '0) begin n_errors++; $display("FAIL reset_lane_idx got %h exp 0", dif.lane_idx); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", err); end
    n_checks++; if (cnt !== CW'(16)) begin n_errors++; $display("FAIL reset_cnt got %0d exp 16", cnt); end
  endtask

  task automatic test_full_group();
    sched_alloc_lane_t [ES-1:0] exp_el;
    exp_el    = '0;
    exp_el[1] = 2'd1;
    exp_el[2] = 2'd2;
    exp_el[3] = 2'd3;
    cyc(1'b1, 4'b1111, '0);
    n_checks++; if (put !== 16'h000F) begin n_errors++; $display("FAIL full_put got %h exp 000f", put); end
    n_checks++; if (dif.lane_idx !== {4'd3, 4'd2, 4'd1, 4'd0}) begin n_errors++; $display("FAIL full_lane_idx got %h exp 3210", dif.lane_idx); end
    n_checks++; if (elane !== exp_el) begin n_errors++; $display("FAIL full_entry_lane got %h exp %h", elane, exp_el); end
    post();
    n_checks++; if (cnt !== CW'(12)) begin n_errors++; $display("FAIL full_cnt got %0d exp 12", cnt); end
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL full_empty got %b exp 0", empty); end
  endtask

  task automatic test_sparse();
    cyc(1'b1, 4'b1010, '0);
    n_checks++; if (put !== 16'h0030) begin n_errors++; $display("FAIL sparse_put got %h exp 0030", put); end
    n_checks++; if (dif.lane_idx !== {4'd5, 4'd0, 4'd4, 4'd0}) begin n_errors++; $display("FAIL sparse_lane_idx got %h exp 5040", dif.lane_idx); end
    n_checks++; if (elane[5] !== 2'd3) begin n_errors++; $display("FAIL sparse_lane5 got %0d exp 3", elane[5]); end
    n_checks++; if (elane[4] !== 2'd1) begin n_errors++; $display("FAIL sparse_lane4 got %0d exp 1", elane[4]); end
    post();
    n_checks++; if (cnt !== CW'(10)) begin n_errors++; $display("FAIL sparse_cnt got %0d exp 10", cnt); end
  endtask

  task automatic test_backpressure();
    cyc(1'b1, 4'b1111, '0);
    n_checks++; if (put !== 16'h03C0) begin n_errors++; $display("FAIL bp_fill1_put got %h exp 03c0", put); end
    post();
    cyc(1'b1, 4'b0111, '0);
    n_checks++; if (put !== 16'h1C00) begin n_errors++; $display("FAIL bp_fill2_put got %h exp 1c00", put); end
    post();
    n_checks++; if (cnt !== CW'(3)) begin n_errors++; $display("FAIL bp_cnt got %0d exp 3", cnt); end
    cyc(1'b1, 4'b0001, '0);
    n_checks++; if (dif.disp_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready got %b exp 0", dif.disp_ready); end
    n_checks++; if (put !== '0) begin n_errors++; $display("FAIL bp_put got %h exp 0", put); end
    post();
    n_checks++; if (cnt !== CW'(3)) begin n_errors++; $display("FAIL bp_stall_cnt got %0d exp 3", cnt); end
    cyc(1'b0, '0, 16'h0080);
    n_checks++; if (dif.disp_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_same_cycle got %b exp 0", dif.disp_ready); end
    post();
    n_checks++; if (cnt !== CW'(4)) begin n_errors++; $display("FAIL bp_free_cnt got %0d exp 4", cnt); end
    n_checks++; if (dif.disp_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_after got %b exp 1", dif.disp_ready); end
    cyc(1'b1, 4'b0001, '0);
    n_checks++; if (put !== 16'h0080) begin n_errors++; $display("FAIL bp_regrant_put got %h exp 0080", put); end
    n_checks++; if (dif.lane_idx[0] !== 4'd7) begin n_errors++; $display("FAIL bp_regrant_idx got %0d exp 7", dif.lane_idx[0]); end
    post();
    n_checks++; if (cnt !== CW'(3)) begin n_errors++; $display("FAIL bp_regrant_cnt got %0d exp 3", cnt); end
  endtask

  task automatic test_finish_during_fire();
    cyc(1'b0, '0, 16'h0170);
    post();
    n_checks++; if (cnt !== CW'(7)) begin n_errors++; $display("FAIL ff_pre_cnt got %0d exp 7", cnt); end
    cyc(1'b1, 4'b1111, 16'h0004);
    n_checks++; if (put !== 16'h0170) begin n_errors++; $display("FAIL ff_put got %h exp 0170", put); end
    post();
    n_checks++; if (cnt !== CW'(4)) begin n_errors++; $display("FAIL ff_cnt got %0d exp 4", cnt); end
    cyc(1'b1, 4'b0001, '0);
    n_checks++; if (put !== 16'h0004) begin n_errors++; $display("FAIL ff_next_put got %h exp 0004", put); end
    n_checks++; if (dif.lane_idx[0] !== 4'd2) begin n_errors++; $display("FAIL ff_next_idx got %0d exp 2", dif.lane_idx[0]); end
    post();
    n_checks++; if (cnt !== CW'(3)) begin n_errors++; $display("FAIL ff_next_cnt got %0d exp 3", cnt); end
  endtask

  task automatic test_double_free();
    cyc(1'b0, '0, 16'h0200);
    post();
    n_checks++; if (cnt !== CW'(4)) begin n_errors++; $display("FAIL df_first_cnt got %0d exp 4", cnt); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL df_first_err got %b exp 0", err); end
    cyc(1'b0, '0, 16'h0200);
    post();
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL df_err got %b exp 1", err); end
    n_checks++; if (cnt !== CW'(4)) begin n_errors++; $display("FAIL df_cnt got %0d exp 4", cnt); end
    cyc(1'b0, '0, '0);
    post();
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL df_sticky got %b exp 1", err); end
    rst = 1'b1;
    cyc(1'b0, '0, '0);
    post();
    rst = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL df_reset_err got %b exp 0", err); end
    n_checks++; if (cnt !== CW'(16)) begin n_errors++; $display("FAIL df_reset_cnt got %0d exp 16", cnt); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL df_reset_empty got %b exp 1", empty); end
  endtask

  task automatic test_empty_group();
    cyc(1'b1, 4'b0000, '0);
    n_checks++; if (dif.disp_ready !== 1'b1) begin n_errors++; $display("FAIL eg_ready got %b exp 1", dif.disp_ready); end
    n_checks++; if (put !== '0) begin n_errors++; $display("FAIL eg_put got %h exp 0", put); end
    n_checks++; if (dif.lane_idx !== '0) begin n_errors++; $display("FAIL eg_lane_idx got %h exp 0", dif.lane_idx); end
    post();
    n_checks++; if (cnt !== CW'(16)) begin n_errors++; $display("FAIL eg_cnt got %0d exp 16", cnt); end
  endtask

  task automatic test_random();
    logic [ES-1:0]                m_free;
    logic [ES-1:0]                avail;
    logic [ES-1:0]                exp_put;
    logic [DISP_SIZE-1:0][EW-1:0] exp_idx;
    sched_alloc_lane_t [ES-1:0]   exp_el;
    logic                         v;
    logic                         exp_ready;
    logic [DISP_SIZE-1:0]         en;
    logic [ES-1:0]                f;
    int                           bad;
    m_free = '1;
    bad    = 0;
    for (int c = 0; c < 10000; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      en = DISP_SIZE'($urandom);
      f  = ~m_free & ES'($urandom) & ES'($urandom);
      cyc(v, en, f);
      exp_ready = ($countones(m_free) >= DISP_SIZE);
      avail   = m_free;
      exp_put = '0;
      exp_idx = '0;
      exp_el  = '0;
      if (v && exp_ready) begin
        for (int k = 0; k < DISP_SIZE; k++) begin
          if (en[k]) begin
            for (int j = 0; j < ES; j++) begin
              if (avail[j]) begin
                exp_idx[k] = EW'(j);
                exp_el[j]  = LW'(k);
                exp_put[j] = 1'b1;
                avail[j]   = 1'b0;
                break;
              end
            end
          end
        end
      end
      n_checks++; if (dif.disp_ready !== exp_ready) begin n_errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, dif.disp_ready, exp_ready); end
      n_checks++; if (put !== exp_put) begin n_errors++; $display("FAIL rnd_put cyc %0d got %h exp %h", c, put, exp_put); end
      n_checks++; if ((put & ~m_free) !== '0) begin n_errors++; $display("FAIL rnd_busy_grant cyc %0d got %h exp 0", c, put & ~m_free); end
      n_checks++; if (dif.lane_idx !== exp_idx) begin n_errors++; $display("FAIL rnd_lane_idx cyc %0d got %h exp %h", c, dif.lane_idx, exp_idx); end
      n_checks++; if (elane !== exp_el) begin n_errors++; $display("FAIL rnd_entry_lane cyc %0d got %h exp %h", c, elane, exp_el); end
      m_free = (m_free & ~exp_put) | f;
      post();
      n_checks++; if (cnt !== CW'($countones(m_free))) begin n_errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", c, cnt, $countones(m_free)); end
      n_checks++; if (empty !== (m_free == '1)) begin n_errors++; $display("FAIL rnd_empty cyc %0d got %b exp %b", c, empty, (m_free == '1)); end
      n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rnd_err cyc %0d got %b exp 0", c, err); end
      if (n_errors > 20) begin
        bad = 1;
        break;
      end
    end
    if (bad != 0) $display("FAIL rnd_abort after too many errors: %0d", n_errors);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b1;
    dif.disp_valid   = 1'b0;
    dif.disp_lane_en = '0;
    fin              = '0;
    test_reset();
    test_full_group();
    test_sparse();
    test_backpressure();
    test_finish_during_fire();
    test_double_free();
    test_empty_group();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_msrh_sched_alloc
